// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: drives the PC, reads a 1-cycle-latency ROM and hands bytes to the decoder.
// Optional macro IFU_PERF_CNT_EN adds the fetch_cnt/flush_cnt performance counters.
module instr_fetch_unit #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc_out,
   output logic              pc_enable,
   output logic              ld,
   output logic [ADDR_W-1:0] inp,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              branch_req,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              halt,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr_data,
   output logic [ADDR_W-1:0] instr_addr,
   input  logic              instr_ready
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [15:0]       fetch_cnt,
   output logic [7:0]        flush_cnt
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int OCC_W = CNT_W + 1;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_REDIRECT = 2'd1,
      ST_HALTED   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               inflight_q, inflight_d;
   logic [ADDR_W-1:0]  fl_addr_q, fl_addr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0]  fifo_data_q [DEPTH];
   logic [ADDR_W-1:0]  fifo_addr_q [DEPTH];

   logic               pop_s;
   logic               push_s;
   logic               issue_s;
   logic               drop_s;
   logic [OCC_W-1:0]   occ_s;

   // Occupancy credits a pop in the same cycle so a ready decoder sees one byte per cycle.
   always_comb begin
      pop_s   = instr_valid & instr_ready & ~branch_req;
      drop_s  = branch_req & inflight_q;
      push_s  = inflight_q & ~drop_s;
      occ_s   = OCC_W'(cnt_q) + OCC_W'(inflight_q) - OCC_W'(pop_s);
      issue_s = reset & ~halt & ~branch_req & (occ_s < OCC_W'(DEPTH));
   end

   // Combinational strobes toward the PC and ROM; all forced low while reset is asserted.
   always_comb begin
      pc_enable = 1'b0;
      mem_rd    = 1'b0;
      mem_addr  = '0;
      ld        = 1'b0;
      inp       = '0;
      if (!reset) begin
         ld = 1'b0;
      end else if (branch_req) begin
         ld  = 1'b1;
         inp = branch_target;
      end else if (issue_s) begin
         pc_enable = 1'b1;
         mem_rd    = 1'b1;
         mem_addr  = pc_out;
      end else begin
         pc_enable = 1'b0;
      end
   end

   always_comb begin
      instr_valid = (cnt_q != '0);
      instr_data  = '0;
      instr_addr  = '0;
      if (instr_valid) begin
         instr_data = fifo_data_q[rd_ptr_q];
         instr_addr = fifo_addr_q[rd_ptr_q];
      end else begin
         instr_data = '0;
      end
   end

   // FIFO bookkeeping: a branch empties the queue and ignores any concurrent pop.
   always_comb begin
      inflight_d = issue_s;
      fl_addr_d  = issue_s ? pc_out : fl_addr_q;
      cnt_d      = cnt_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (branch_req) begin
         cnt_d    = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         cnt_d    = cnt_q + CNT_W'(push_s) - CNT_W'(pop_s);
         wr_ptr_d = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
         rd_ptr_d = pop_s ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (branch_req)  state_d = ST_REDIRECT;
            else if (halt)   state_d = ST_HALTED;
            else             state_d = ST_RUN;
         end
         ST_REDIRECT: state_d = ST_RUN;
         ST_HALTED: begin
            if (branch_req)  state_d = ST_HALTED;
            else if (!halt)  state_d = ST_RUN;
            else             state_d = ST_HALTED;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_RUN;
         inflight_q <= 1'b0;
         fl_addr_q  <= '0;
         cnt_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         inflight_q <= inflight_d;
         fl_addr_q  <= fl_addr_d;
         cnt_q      <= cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_data_q[i] <= '0;
            fifo_addr_q[i] <= '0;
         end
      end else if (push_s) begin
         fifo_data_q[wr_ptr_q] <= mem_data;
         fifo_addr_q[wr_ptr_q] <= fl_addr_q;
      end
   end

`ifdef IFU_PERF_CNT_EN
   logic [15:0] fetch_cnt_q;
   logic [7:0]  flush_cnt_q;
   logic        flush_hit_s;

   assign flush_hit_s = branch_req & ((cnt_q != '0) | inflight_q);
   assign fetch_cnt   = fetch_cnt_q;
   assign flush_cnt   = flush_cnt_q;

   // Saturating event counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_cnt_q <= 16'd0;
         flush_cnt_q <= 8'd0;
      end else begin
         if (pop_s && (fetch_cnt_q != 16'hFFFF)) fetch_cnt_q <= fetch_cnt_q + 16'd1;
         if (flush_hit_s && (flush_cnt_q != 8'hFF)) flush_cnt_q <= flush_cnt_q + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a PC/ROM model and a queue-based delivery scoreboard.
module tb_instr_fetch_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] pc_out;
   logic       pc_enable, ld, mem_rd;
   logic [7:0] inp, mem_addr, mem_data;
   logic       branch_req, halt, instr_ready, instr_valid;
   logic [7:0] branch_target, instr_data, instr_addr;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] d;
   } exp_t;

   exp_t exp_q[$];
   int   n_total = 0;
   int   n_bad   = 0;
   int   iss     = 0;

   always #5 clk = ~clk;

   instr_fetch_unit dut (
      .clk(clk), .reset(reset), .pc_out(pc_out), .pc_enable(pc_enable), .ld(ld), .inp(inp),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data), .branch_req(branch_req),
      .branch_target(branch_target), .halt(halt), .instr_valid(instr_valid),
      .instr_data(instr_data), .instr_addr(instr_addr), .instr_ready(instr_ready)
   );

   // Program counter and ROM environment; ROM[a] = a ^ A0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)         pc_out <= 8'h00;
      else if (ld)        pc_out <= inp;
      else if (pc_enable) pc_out <= pc_out + 8'h01;
   end

   always_ff @(posedge clk) begin
      if (mem_rd) mem_data <= mem_addr ^ 8'hA0;
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_byte(input logic [7:0] a, input logic [7:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_mem_rd"}, mem_rd, 16'h0);
      chk({tag, "_pc_en"}, pc_enable, 16'h0);
      chk({tag, "_ld"}, ld, 16'h0);
      chk({tag, "_inp"}, inp, 16'h0);
      chk({tag, "_mem_addr"}, mem_addr, 16'h0);
      chk({tag, "_valid"}, instr_valid, 16'h0);
      chk({tag, "_data"}, instr_data, 16'h0);
      chk({tag, "_addr"}, instr_addr, 16'h0);
   endtask

   // Monitor: every accepted head byte is compared against the scoreboard queue.
   always @(negedge clk) begin : mon
      exp_t e;
      if (reset === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL unexpected_delivery: got %h@%h want none", instr_data, instr_addr);
         end else begin
            e = exp_q.pop_front();
            chk("deliver", {instr_addr, instr_data}, {e.a, e.d});
         end
      end
   end

   initial begin
      reset = 1'b0; halt = 1'b0; branch_req = 1'b0; branch_target = 8'h00; instr_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk_zero_outputs("rst");

      // Free run from reset
      cyc();
      reset = 1'b1; instr_ready = 1'b1;
      expect_byte(8'h00, 8'hA0); expect_byte(8'h01, 8'hA1);
      expect_byte(8'h02, 8'hA2); expect_byte(8'h03, 8'hA3);
      @(negedge clk);
      chk("t1_mem_rd", mem_rd, 16'h1);
      chk("t1_mem_addr0", mem_addr, 16'h00);
      chk("t1_pc_en", pc_enable, 16'h1);
      chk("t1_ld", ld, 16'h0);
      chk("t1_valid_c0", instr_valid, 16'h0);
      cyc(); @(negedge clk);
      chk("t1_valid_c1", instr_valid, 16'h0);
      chk("t1_mem_addr1", mem_addr, 16'h01);
      cyc(); @(negedge clk);
      chk("t1_valid_c2", instr_valid, 16'h1);
      chk("t1_pc2", pc_out, 16'h02);
      cyc(); @(negedge clk);
      chk("t1_pc3", pc_out, 16'h03);
      cyc();
      halt = 1'b1;
      @(negedge clk);
      chk("t1_halt_rd", mem_rd, 16'h0);
      chk("t1_halt_pcen", pc_enable, 16'h0);
      repeat (4) cyc();
      @(negedge clk);
      chk("t1_pc_end", pc_out, 16'h04);
      chk("t1_drain", exp_q.size(), 16'h0);

      // Decoder stalled: only two issues fit
      cyc();
      reset = 1'b0;
      cyc();
      reset = 1'b1; halt = 1'b0; instr_ready = 1'b0; iss = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (mem_rd) begin
            chk("t2_addr", mem_addr, 16'(iss));
            iss++;
         end
         cyc();
      end
      chk("t2_issues", iss, 16'd2);
      @(negedge clk);
      chk("t2_rd_idle", mem_rd, 16'h0);
      chk("t2_pcen_idle", pc_enable, 16'h0);
      chk("t2_valid", instr_valid, 16'h1);
      chk("t2_pc", pc_out, 16'h02);
      cyc();
      expect_byte(8'h00, 8'hA0); expect_byte(8'h01, 8'hA1); expect_byte(8'h02, 8'hA2);
      instr_ready = 1'b1;
      @(negedge clk);
      chk("t2_resume_rd", mem_rd, 16'h1);
      chk("t2_resume_addr", mem_addr, 16'h02);
      cyc();
      halt = 1'b1;
      repeat (4) cyc();
      @(negedge clk);
      chk("t2_drain", exp_q.size(), 16'h0);
      chk("t2_pc_end", pc_out, 16'h03);

      // Branch with one FIFO entry and one read in flight
      cyc();
      halt = 1'b0; instr_ready = 1'b0;
      cyc();
      cyc();
      branch_req = 1'b1; branch_target = 8'h18;
      @(negedge clk);
      chk("t3_ld", ld, 16'h1);
      chk("t3_inp", inp, 16'h18);
      chk("t3_pcen", pc_enable, 16'h0);
      chk("t3_rd", mem_rd, 16'h0);
      chk("t3_fifo1", instr_valid, 16'h1);
      cyc();
      branch_req = 1'b0; branch_target = 8'h00; instr_ready = 1'b1;
      expect_byte(8'h18, 8'hB8); expect_byte(8'h19, 8'hB9);
      @(negedge clk);
      chk("t3_ld_off", ld, 16'h0);
      chk("t3_pc", pc_out, 16'h18);
      chk("t3_issue", mem_addr, 16'h18);
      chk("t3_flushed", instr_valid, 16'h0);
      cyc(); @(negedge clk);
      chk("t3_stale_dropped", instr_valid, 16'h0);
      cyc();
      halt = 1'b1;
      @(negedge clk);
      chk("t3_valid", instr_valid, 16'h1);

      // Halt holds fetch, then resumes at the same PC
      for (int i = 0; i < 5; i++) begin
         cyc(); @(negedge clk);
         chk("t4_halt_rd", mem_rd, 16'h0);
      end
      chk("t4_pc_held", pc_out, 16'h1A);
      chk("t4_drain", exp_q.size(), 16'h0);
      cyc();
      halt = 1'b0;
      expect_byte(8'h1A, 8'hBA);
      @(negedge clk);
      chk("t4_resume_addr", mem_addr, 16'h1A);
      cyc();
      halt = 1'b1;
      repeat (3) cyc();
      branch_req = 1'b1; branch_target = 8'hFE;
      @(negedge clk);
      chk("t4_halt_ld", ld, 16'h1);
      chk("t4_halt_inp", inp, 16'hFE);
      cyc();
      branch_req = 1'b0; branch_target = 8'h00;
      @(negedge clk);
      chk("t4_still_halted", mem_rd, 16'h0);
      chk("t4_pc_fe", pc_out, 16'hFE);

      // Address wrap
      cyc();
      halt = 1'b0;
      expect_byte(8'hFE, 8'h5E); expect_byte(8'hFF, 8'h5F);
      expect_byte(8'h00, 8'hA0); expect_byte(8'h01, 8'hA1);
      @(negedge clk);
      chk("t5_addr_fe", mem_addr, 16'hFE);
      cyc(); @(negedge clk);
      chk("t5_addr_ff", mem_addr, 16'hFF);
      cyc(); @(negedge clk);
      chk("t5_pc_wrap", pc_out, 16'h00);
      cyc();
      cyc();
      halt = 1'b1;
      repeat (4) cyc();
      @(negedge clk);
      chk("t5_drain", exp_q.size(), 16'h0);
      chk("t5_pc_end", pc_out, 16'h02);

      // Async reset with the FIFO full
      cyc();
      halt = 1'b0; instr_ready = 1'b0;
      repeat (3) cyc();
      chk("t6_full_before", instr_valid, 16'h1);
      #2;
      reset = 1'b0;
      #1;
      chk_zero_outputs("t6");
      chk("t6_pc_reset", pc_out, 16'h00);
      cyc();
      reset = 1'b1; instr_ready = 1'b1;
      expect_byte(8'h00, 8'hA0);
      @(negedge clk);
      chk("t6_restart_rd", mem_rd, 16'h1);
      chk("t6_restart_addr", mem_addr, 16'h00);
      cyc();
      halt = 1'b1;
      repeat (4) cyc();
      @(negedge clk);
      chk("t6_drain", exp_q.size(), 16'h0);
      chk("t6_empty", instr_valid, 16'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
